// File: rtl/half_adder_pkg.sv
// Shared constants and types for the registered half adder and its statistics block.
package half_adder_pkg;

    localparam int unsigned STAT_W_DEFAULT = 8;

    // Operand combination index, ordered as {a, b}.
    typedef enum logic [1:0] {
        COMBO_00 = 2'd0,
        COMBO_01 = 2'd1,
        COMBO_10 = 2'd2,
        COMBO_11 = 2'd3
    } ha_combo_e;

endpackage

// File: rtl/ha_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module ha_sat_counter #(
    parameter int unsigned STAT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              inc,
    output logic [STAT_W-1:0] count
);

    localparam logic [STAT_W-1:0] ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic [STAT_W-1:0] count_q;
    logic [STAT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/half_adder_core.sv
// Registered half adder with valid qualifier. Define HALF_ADDER_STATS_EN to build the
// per-combination saturating input counters and the stat_* ports.
module half_adder_core
    import half_adder_pkg::*;
#(
    parameter int unsigned STAT_W = STAT_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_in,
    input  logic              b_in,
    input  logic              in_valid,
    output logic              sum,
    output logic              carry,
    output logic              out_valid
`ifdef HALF_ADDER_STATS_EN
    ,
    input  logic [1:0]        stat_sel,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_count
`endif
);

    if ((STAT_W < 2) || (STAT_W > 16)) begin : g_bad_stat_w
        $error("half_adder_core: STAT_W must be in 2..16");
    end

    logic sum_q, sum_d;
    logic carry_q, carry_d;
    logic valid_q;

    // Operands are only looked at when qualified, so X/Z while idle cannot leak through.
    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        if (in_valid) begin
            sum_d   = a_in ^ b_in;
            carry_d = a_in & b_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= in_valid;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = valid_q;

`ifdef HALF_ADDER_STATS_EN
    logic [STAT_W-1:0] cnt [4];
    logic [1:0]        combo;

    assign combo = {a_in, b_in};

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        ha_sat_counter #(
            .STAT_W (STAT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (stat_clr),
            .inc   (in_valid && (combo == 2'(i))),
            .count (cnt[i])
        );
    end

    always_comb begin
        stat_count = '0;
        unique case (ha_combo_e'(stat_sel))
            COMBO_00: stat_count = cnt[0];
            COMBO_01: stat_count = cnt[1];
            COMBO_10: stat_count = cnt[2];
            COMBO_11: stat_count = cnt[3];
            default:  stat_count = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_half_adder_core.sv
// Directed self-checking bench for half_adder_core; stats scenarios run when
// HALF_ADDER_STATS_EN is defined.
module tb_half_adder_core;

    localparam int unsigned STAT_W = 2;

    logic clk;
    logic rst_n;
    logic a_in;
    logic b_in;
    logic in_valid;
    logic sum;
    logic carry;
    logic out_valid;
`ifdef HALF_ADDER_STATS_EN
    logic [1:0]        stat_sel;
    logic              stat_clr;
    logic [STAT_W-1:0] stat_count;
`endif

    int total;
    int bad;

    half_adder_core #(
        .STAT_W (STAT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a_in       (a_in),
        .b_in       (b_in),
        .in_valid   (in_valid),
        .sum        (sum),
        .carry      (carry),
        .out_valid  (out_valid)
`ifdef HALF_ADDER_STATS_EN
        ,
        .stat_sel   (stat_sel),
        .stat_clr   (stat_clr),
        .stat_count (stat_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        // Reset state, sampled before any release.
        @(negedge clk);
        total++; if (sum !== 1'b0) begin bad++; $display("FAIL reset_sum got=%b exp=0", sum); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        rst_n = 1'b1;
        // Load a 1,1 result, then assert reset mid-cycle with valid still high.
        a_in = 1'b1; b_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL pre_reset_carry got=%b exp=1", carry); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (sum !== 1'b0) begin bad++; $display("FAIL async_sum got=%b exp=0", sum); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL async_carry got=%b exp=0", carry); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b exp=0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL post_reset_carry got=%b exp=1", carry); end
        total++; if (sum !== 1'b0) begin bad++; $display("FAIL post_reset_sum got=%b exp=0", sum); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL post_reset_valid got=%b exp=1", out_valid); end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_truth_table();
        logic [1:0] ops [4];
        logic [1:0] exp [4];  // {sum, carry}
        ops = '{2'b00, 2'b01, 2'b10, 2'b11};
        exp = '{2'b00, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < 4; i++) begin
            a_in = ops[i][1]; b_in = ops[i][0]; in_valid = 1'b1;
            @(negedge clk);
            total++;
            if (sum !== exp[i][1]) begin
                bad++; $display("FAIL tt_sum[%0d] got=%b exp=%b", i, sum, exp[i][1]);
            end
            total++;
            if (carry !== exp[i][0]) begin
                bad++; $display("FAIL tt_carry[%0d] got=%b exp=%b", i, carry, exp[i][0]);
            end
            total++;
            if (out_valid !== 1'b1) begin
                bad++; $display("FAIL tt_valid[%0d] got=%b exp=1", i, out_valid);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold();
        a_in = 1'b1; b_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        total++; if (sum !== 1'b1) begin bad++; $display("FAIL hold_load_sum got=%b exp=1", sum); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL hold_load_valid got=%b exp=1", out_valid); end
        a_in = 1'b1; b_in = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        total++; if (sum !== 1'b1) begin bad++; $display("FAIL hold_sum got=%b exp=1", sum); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL hold_carry got=%b exp=0", carry); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hold_valid got=%b exp=0", out_valid); end
        // Unknown operands while idle must not disturb the held result.
        a_in = 1'bx; b_in = 1'bz;
        @(negedge clk);
        total++; if (sum !== 1'b1) begin bad++; $display("FAIL x_hold_sum got=%b exp=1", sum); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL x_hold_carry got=%b exp=0", carry); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL x_hold_valid got=%b exp=0", out_valid); end
        a_in = 1'b0; b_in = 1'b0;
    endtask

`ifdef HALF_ADDER_STATS_EN
    task automatic test_stats();
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a_in = 1'b1; b_in = 1'b1; in_valid = 1'b1;
            @(negedge clk);
        end
        a_in = 1'b0; b_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        stat_sel = 2'd3; #1;
        total++; if (stat_count !== 2'd3) begin bad++; $display("FAIL stat_11 got=%0d exp=3", stat_count); end
        stat_sel = 2'd1; #1;
        total++; if (stat_count !== 2'd1) begin bad++; $display("FAIL stat_01 got=%0d exp=1", stat_count); end
        stat_sel = 2'd0; #1;
        total++; if (stat_count !== 2'd0) begin bad++; $display("FAIL stat_00 got=%0d exp=0", stat_count); end
        stat_sel = 2'd2; #1;
        total++; if (stat_count !== 2'd0) begin bad++; $display("FAIL stat_10 got=%0d exp=0", stat_count); end
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s); #1;
            total++;
            if (stat_count !== 2'd0) begin
                bad++; $display("FAIL stat_clr[%0d] got=%0d exp=0", s, stat_count);
            end
        end
    endtask

    task automatic test_saturation();
        stat_sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            a_in = 1'b0; b_in = 1'b0; in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0; #1;
        total++; if (stat_count !== 2'd3) begin bad++; $display("FAIL sat_00 got=%0d exp=3", stat_count); end
        a_in = 1'b0; b_in = 1'b0; in_valid = 1'b1; stat_clr = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; stat_clr = 1'b0; #1;
        total++; if (stat_count !== 2'd0) begin bad++; $display("FAIL clr_priority got=%0d exp=0", stat_count); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_cycle_valid got=%b exp=1", out_valid); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        rst_n = 1'b0;
        a_in = 1'b0;
        b_in = 1'b0;
        in_valid = 1'b0;
`ifdef HALF_ADDER_STATS_EN
        stat_sel = 2'd0;
        stat_clr = 1'b0;
`endif
        test_reset();
        test_truth_table();
        test_hold();
`ifdef HALF_ADDER_STATS_EN
        test_stats();
        test_saturation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/half_adder_core.md
# half_adder_core

Registered single-bit half adder with a valid qualifier and optional per-combination input statistics. It sums two 1-bit operands into `sum` and `carry`, one clock after a qualified input. It is the leaf arithmetic cell of the 4-bit ALU datapath. The optional statistics block counts how often each operand combination occurs, for coverage and debug.

## Interface
Parameters:
- `STAT_W`, default 8: width of each statistics counter. Legal range is 2–16.

Ports:
- `clk`  input  1  single clock; every register updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous and active-low.
- `a_in`  input  1  operand A.
- `b_in`  input  1  operand B.
- `in_valid`  input  1  operands are qualified this cycle.
- `sum`  output  1  registered A XOR B.
- `carry`  output  1  registered A AND B.
- `out_valid`  output  1  `sum`/`carry` hold a fresh result this cycle.
- `stat_sel`  input  2  selects a counter, indexed as {a,b}: 0=00, 1=01, 2=10, 3=11.
- `stat_clr`  input  1  synchronous clear of all counters.
- `stat_count`  output  STAT_W  value of the selected counter.

The `stat_*` ports exist only when `HALF_ADDER_STATS_EN` is defined.

## Operation
- On a rising edge with `in_valid`=1:
  - `sum` <= `a_in` ^ `b_in`.
  - `carry` <= `a_in` & `b_in`.
  - `out_valid` <= 1.
- On a rising edge with `in_valid`=0:
  - `sum` and `carry` hold their previous values.
  - `out_valid` <= 0.
- Truth table:
  - 00 → sum 0, carry 0.
  - 01 → sum 1, carry 0.
  - 10 → sum 1, carry 0.
  - 11 → sum 0, carry 1.
- X/Z on operands while `in_valid`=0 has no effect on the outputs.
- Statistics counters (when enabled):
  - Each qualified input increments the counter indexed by {a_in,b_in} by 1.
  - A counter saturates at 2^STAT_W−1 and never wraps.
  - `stat_clr` zeroes all four counters and has priority over an increment in the same cycle.
  - `stat_count` is a combinational read of the counter selected by `stat_sel`. It reflects the registered count, so an increment is visible in the cycle after the qualifying edge.
- There is no backpressure. Every qualified input produces exactly one `out_valid` pulse.

## Timing
- Latency is one cycle from `in_valid` sampled high to `out_valid` high with the result.
- Throughput is one result per cycle. Back-to-back valid inputs produce back-to-back `out_valid` cycles.
- Reset values:
  - `sum`=0, `carry`=0, `out_valid`=0.
  - All counters = 0, so `stat_count`=0.
- Reset is asynchronous on assertion. Outputs go to their reset values immediately, including mid-stream; any in-flight result is discarded.
- Reset is released synchronously to `clk` by the system. The first edge after deassertion samples inputs normally.

## Configuration
- `HALF_ADDER_STATS_EN` defined:
  - The four STAT_W-bit saturating counters are built.
  - The `stat_sel`, `stat_clr` and `stat_count` ports are present.
- `HALF_ADDER_STATS_EN` undefined:
  - The counters and the `stat_*` ports are absent.
  - The adder datapath and its timing are identical in both builds.

## Structure
- Shared package `half_adder_pkg` holds:
  - The `STAT_W` default constant.
  - Enum `ha_combo_e` with values `COMBO_00`, `COMBO_01`, `COMBO_10`, `COMBO_11`, used for `stat_sel` decoding.
- Sub-module `ha_sat_counter`:
  - Parameterized STAT_W-bit saturating counter with `clk`, `rst_n`, `clr`, `inc` inputs and a `count` output.
  - Instantiated four times, inside the `HALF_ADDER_STATS_EN` region only.

## Test plan
- Reset: assert `rst_n`=0 mid-run → `sum`=0, `carry`=0, `out_valid`=0 immediately, without waiting for a clock edge. Release the reset, then apply 1,1 → carry=1 one cycle later.
- Truth table: apply 00, 01, 10, 11 with `in_valid`=1 on consecutive cycles → (sum,carry) = (0,0), (1,0), (1,0), (0,1) on the following cycles, with `out_valid` high for 4 cycles.
- Hold: apply 1,0 valid, then 1,1 with `in_valid`=0 → `sum` stays 1, `carry` stays 0, and `out_valid` drops to 0.
- Statistics (enabled): apply 3×11 and 1×01 → `stat_sel`=3 reads 3 and `stat_sel`=1 reads 1. Pulse `stat_clr` → all counters read 0.
- Saturation (STAT_W=2, enabled): apply 5×00 → `stat_count` for `stat_sel`=0 equals 3. Assert `stat_clr` together with a valid 00 → the counter reads 0.
- Build without the macro: the truth-table scenario passes unchanged.
